// File: rtl/fifo_wr_arbiter.sv
// Round-robin, packet-granular write arbiter sharing one FIFO write port
// among NUM_REQ requesters. A grant is held until the last beat is accepted
// or MAX_BEATS beats have gone through, whichever comes first.
module fifo_wr_arbiter #(
  parameter int NUM_REQ      = 4,
  parameter int REQ_ID_WIDTH = 2,
  parameter int DATA_WIDTH   = 8,
  parameter int MAX_BEATS    = 16,
  parameter int CNT_WIDTH    = 5
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ-1:0]            req_last,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic                          fifo_full,
  output logic                          fifo_wr_rqst,
  output logic [DATA_WIDTH-1:0]         fifo_wr_data,
  output logic                          grant_active,
  output logic [REQ_ID_WIDTH-1:0]       grant_id,
  output logic                          pkt_err
);

  typedef enum logic {
    IDLE = 1'b0,
    XFER = 1'b1
  } state_t;

  state_t                  state_q, state_d;
  logic [REQ_ID_WIDTH-1:0] grantId_q, grantId_d;
  logic [CNT_WIDTH-1:0]    beatCnt_q, beatCnt_d;
  logic                    pktErr_q, pktErr_d;

  logic [REQ_ID_WIDTH-1:0] selId;
  logic                    selFound;
  logic                    accept;
  logic [DATA_WIDTH-1:0]   dataArr [NUM_REQ];

  // Unpack the flat data bus so the write-data mux indexes by requester id
  for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
    assign dataArr[i] = req_data[i*DATA_WIDTH +: DATA_WIDTH];
  end

  // Round-robin search starting one past the last grant, wrapping around
  always_comb begin
    logic [REQ_ID_WIDTH-1:0] idx;
    selFound = 1'b0;
    selId    = grantId_q;
    idx      = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = REQ_ID_WIDTH'((int'(grantId_q) + k) % NUM_REQ);
      if (!selFound && req_valid[idx]) begin
        selFound = 1'b1;
        selId    = idx;
      end
    end
  end

  // Next-state and handshake logic; writes are gated by full so none is dropped
  always_comb begin
    state_d      = state_q;
    grantId_d    = grantId_q;
    beatCnt_d    = beatCnt_q;
    pktErr_d     = pktErr_q;
    req_ready    = '0;
    accept       = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (selFound) begin
          grantId_d = selId;
          beatCnt_d = '0;
          state_d   = XFER;
        end
      end
      XFER: begin
        req_ready[grantId_q] = !fifo_full;
        accept               = req_valid[grantId_q] & !fifo_full;
        if (accept) begin
          beatCnt_d = beatCnt_q + 1'b1;
          if (req_last[grantId_q]) begin
            state_d = IDLE;
          end else if (beatCnt_q == CNT_WIDTH'(MAX_BEATS - 1)) begin
            state_d  = IDLE;
            pktErr_d = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State register; reset abandons any packet in flight
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      grantId_q <= REQ_ID_WIDTH'(NUM_REQ - 1);
      beatCnt_q <= '0;
      pktErr_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      grantId_q <= grantId_d;
      beatCnt_q <= beatCnt_d;
      pktErr_q  <= pktErr_d;
    end
  end

  assign fifo_wr_rqst = accept;
  assign fifo_wr_data = dataArr[grantId_q];
  assign grant_active = (state_q == XFER);
  assign grant_id     = grantId_q;
  assign pkt_err      = pktErr_q;

endmodule

// File: doc/fifo_wr_arbiter.md
Name: fifo_wr_arbiter

Overview:
- Round-robin write arbiter that shares one FIFO write port among NUM_REQ packet-oriented requesters.
- Grants at packet granularity: holds the grant until the beat carrying last is accepted, or until MAX_BEATS beats have been accepted.
- Drives the FIFO controller's wr_rqst and muxes write data; uses the FIFO full flag for backpressure.
- Sits in front of the FIFO controller in the interconnect converters.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- REQ_ID_WIDTH, 2, width of grant_id; must satisfy 2**REQ_ID_WIDTH >= NUM_REQ.
- DATA_WIDTH, 8, width of one data beat.
- MAX_BEATS, 16, maximum beats per grant before forced release (>=2).
- CNT_WIDTH, 5, beat counter width; must satisfy 2**CNT_WIDTH > MAX_BEATS.

Ports:
- clk  input  1  clock; all logic on rising edge.
- rst  input  1  reset; synchronous, active-high.
- req_valid  input  NUM_REQ  per-requester beat valid.
- req_last  input  NUM_REQ  per-requester last beat of packet.
- req_data  input  NUM_REQ*DATA_WIDTH  per-requester data; requester i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- req_ready  output  NUM_REQ  per-requester beat accepted (combinational).
- fifo_full  input  1  full flag from the FIFO controller.
- fifo_wr_rqst  output  1  write request to the FIFO (combinational).
- fifo_wr_data  output  DATA_WIDTH  data to the FIFO (combinational mux).
- grant_active  output  1  arbiter is in XFER state (registered).
- grant_id  output  REQ_ID_WIDTH  current or last granted requester (registered).
- pkt_err  output  1  sticky flag: a grant was force-released at MAX_BEATS without last (registered).

Behaviour:
- States: IDLE, XFER.
- Reset (rst=1 at a clock edge): state=IDLE, grant_active=0, grant_id=NUM_REQ-1 (so requester 0 has first priority), beat_cnt=0, pkt_err=0.
- Reset overrides everything, including mid-packet. The interrupted packet is abandoned and no further FIFO write occurs from the next cycle.
- IDLE:
  - req_ready=0, fifo_wr_rqst=0.
  - If any req_valid is high, select the first requester with valid=1, searching from (grant_id+1) mod NUM_REQ upward with wrap.
  - Register the selection into grant_id, set grant_active=1, clear beat_cnt, go to XFER.
  - Arbitration latency is 1 cycle: the first beat can be accepted in the cycle after the request is seen.
- XFER, with g=grant_id:
  - accept = req_valid[g] & !fifo_full.
  - req_ready[g] = !fifo_full; all other req_ready bits = 0.
  - fifo_wr_rqst = accept.
  - fifo_wr_data = req_data[g] regardless of accept.
  - On accept: beat_cnt increments.
  - On accept & req_last[g]: go to IDLE.
  - On accept & !req_last[g] & beat_cnt==MAX_BEATS-1: go to IDLE and set pkt_err=1.
  - Otherwise remain in XFER. valid may drop between beats; the grant is held.
- Other requesters' valid/last/data are ignored while in XFER. No preemption.
- There is one dead IDLE cycle between consecutive grants.
- Fairness:
  - The pointer advances only via grant_id, so the requester just served has the lowest priority at the next arbitration.
  - With all NUM_REQ requesters continuously requesting, grants rotate 0,1,2,3,0,...
- fifo_full asserted mid-packet stalls the transfer with no state change and the beat is held.
- Because fifo_wr_rqst is gated by !fifo_full, the arbiter never issues a write that the FIFO will drop.
- pkt_err clears only on rst.
- A requester whose valid rises while another holds the grant waits. Worst-case wait is (NUM_REQ-1) grants of up to MAX_BEATS beats each, plus one idle cycle per grant.
- grant_id stays at its last value in IDLE; it is valid to observe only when grant_active=1.

Test Plan:
1. Reset, then req_valid=4'b0001 with a 3-beat packet (data 0x11,0x12,0x13, last on beat 3), fifo_full=0 -> grant_active rises 1 cycle after valid, grant_id=0; fifo_wr_rqst high for 3 consecutive cycles with data 0x11,0x12,0x13; IDLE on the next cycle; pkt_err=0.
2. req_valid=4'b1111 held, every packet 1 beat with last=1 -> grant_id sequence 0,1,2,3,0; each grant separated by one IDLE cycle; exactly one FIFO write per grant.
3. Requester 2 mid-packet (beat 2 of 4) with fifo_full raised for 5 cycles -> fifo_wr_rqst=0 and req_ready[2]=0 for those 5 cycles; grant_id stays 2; after full drops, beats 3-4 are written in order and the transfer completes.
4. Requester 1 sends 20 beats with last never asserted, MAX_BEATS=16 -> exactly 16 FIFO writes, return to IDLE, pkt_err=1 and stays 1; with requester 3 also requesting, the next grant goes to requester 3.
5. rst pulsed for 1 cycle on beat 2 of a 5-beat packet from requester 0 -> from the next cycle grant_active=0, fifo_wr_rqst=0, pkt_err=0, grant_id=3; the next arbitration starts from requester 0.
6. Requester 3 valid drops for 2 cycles mid-packet while requester 0 is requesting -> grant stays on 3 with no FIFO writes during the gap; requester 0 is granted only after requester 3's last beat.
